// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer: one shared prescaler and period counter drive NCH compare
// channels; period, compares, prescaler and mode are shadowed and change only at update events.
module pwm_timer_mc #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int PSC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PWM_EN,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     AAR,
  input  logic [PSC_W-1:0]     PSC,
  input  logic [NCH*WIDTH-1:0] CCR,
  input  logic [NCH-1:0]       POL,
  input  logic                 UG,
  output logic [WIDTH-1:0]     cnt_val,
  output logic                 dir,
  output logic                 upd_evt,
  output logic [NCH-1:0]       pwm_out
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_UPDOWN = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  mode_e            mode_sh;
  logic [WIDTH-1:0] aar_sh;
  logic [WIDTH-1:0] ccr_sh [NCH];
  logic [PSC_W-1:0] psc_sh;
  logic [PSC_W-1:0] psc_cnt;

  logic             tick;
  logic             evt;
  logic             start_dir;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_nxt;
  logic [PSC_W-1:0] psc_nxt;
  logic [NCH-1:0]   pwm_nxt;

  assign tick      = (psc_cnt == psc_sh);
  // Start direction always follows the incoming mode, since it is the one being loaded.
  assign start_dir = (mode_e'(mode) == MODE_DOWN);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cnt_nxt = cnt_val;
    dir_nxt = dir;
    psc_nxt = psc_cnt;
    evt     = 1'b0;
    if (!PWM_EN) begin
      cnt_nxt = '0;
      psc_nxt = '0;
      dir_nxt = start_dir;
    end else if (UG) begin
      cnt_nxt = '0;
      psc_nxt = '0;
      dir_nxt = start_dir;
      evt     = 1'b1;
    end else if (tick) begin
      psc_nxt = '0;
      case (mode_sh)
        MODE_DOWN: begin
          dir_nxt = 1'b1;
          if (cnt_val == '0) begin
            cnt_nxt = aar_sh;
            evt     = 1'b1;
          end else begin
            cnt_nxt = cnt_val - CNT_ONE;
          end
        end
        MODE_UPDOWN: begin
          if (!dir) begin
            if (aar_sh == '0) begin
              // Zero period: hold at 0 rather than turning round below zero.
              cnt_nxt = '0;
              evt     = 1'b1;
            end else if (cnt_val >= aar_sh) begin
              dir_nxt = 1'b1;
              cnt_nxt = cnt_val - CNT_ONE;
            end else begin
              cnt_nxt = cnt_val + CNT_ONE;
            end
          end else if (cnt_val == '0) begin
            dir_nxt = 1'b0;
            cnt_nxt = CNT_ONE;
            evt     = 1'b1;
          end else begin
            cnt_nxt = cnt_val - CNT_ONE;
          end
        end
        default: begin
          dir_nxt = 1'b0;
          if (cnt_val >= aar_sh) begin
            cnt_nxt = '0;
            evt     = 1'b1;
          end else begin
            cnt_nxt = cnt_val + CNT_ONE;
          end
        end
      endcase
      if (evt) dir_nxt = start_dir;
    end else begin
      psc_nxt = psc_cnt + PSC_ONE;
    end
  end

  always_comb begin
    pwm_nxt = POL;
    for (int i = 0; i < NCH; i++) begin
      pwm_nxt[i] = POL[i] ^ (PWM_EN && (cnt_val < ccr_sh[i]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val <= '0;
      dir     <= 1'b0;
      upd_evt <= 1'b0;
      pwm_out <= '0;
      psc_cnt <= '0;
    end else begin
      cnt_val <= cnt_nxt;
      dir     <= dir_nxt;
      upd_evt <= evt;
      pwm_out <= pwm_nxt;
      psc_cnt <= psc_nxt;
    end
  end

  // NOTE: the shadow array is small and must start from a known zero configuration, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aar_sh  <= '0;
      psc_sh  <= '0;
      mode_sh <= MODE_UP;
      for (int i = 0; i < NCH; i++) ccr_sh[i] <= '0;
    end else if (!PWM_EN || evt) begin
      aar_sh  <= AAR;
      psc_sh  <= PSC;
      mode_sh <= mode_e'(mode);
      for (int i = 0; i < NCH; i++) ccr_sh[i] <= CCR[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_pwm_timer_mc.sv
// Directed bench for pwm_timer_mc: reset, up / up-down / down counting, preload,
// polarity, UG colliding with a wrap, and asynchronous reset mid-run.
module tb_pwm_timer_mc;
  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int PSC_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 pwm_en;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     aar;
  logic [PSC_W-1:0]     psc;
  logic [NCH*WIDTH-1:0] ccr;
  logic [NCH-1:0]       pol;
  logic                 ug;
  logic [WIDTH-1:0]     cnt_val;
  logic                 dir;
  logic                 upd_evt;
  logic [NCH-1:0]       pwm_out;

  int total = 0;
  int bad   = 0;

  pwm_timer_mc #(.WIDTH(WIDTH), .NCH(NCH), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst_n(rst_n), .PWM_EN(pwm_en), .mode(mode), .AAR(aar), .PSC(psc),
    .CCR(ccr), .POL(pol), .UG(ug), .cnt_val(cnt_val), .dir(dir), .upd_evt(upd_evt),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input bit d, input bit u,
                           input logic [3:0] p);
    check($sformatf("%s cnt", tag), 32'(cnt_val), 32'(c));
    check($sformatf("%s dir", tag), 32'(dir), 32'(d));
    check($sformatf("%s upd", tag), 32'(upd_evt), 32'(u));
    check($sformatf("%s pwm", tag), 32'(pwm_out), 32'(p));
  endtask

  // Up run: AAR=9 until the update at edge 40, then AAR=5.
  function automatic int up_cnt(int k);
    if (k <= 40) return k % 10;
    return (k - 40) % 6;
  endfunction

  // Up-down, AAR=4, PSC=2: one tick every 3 clk, 8 ticks per period.
  function automatic int ud_cnt(int k);
    int p;
    p = (k / 3) % 8;
    return (p <= 4) ? p : 8 - p;
  endfunction

  // Down, AAR=7, PSC=0: first tick after enable loads 7.
  function automatic int dn_cnt(int k);
    if (k == 0) return 0;
    return 7 - ((k - 1) % 8);
  endfunction

  // Up, AAR=3, PSC=2, counted from the UG edge.
  function automatic int ug_cnt(int j);
    return (j / 3) % 4;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pwm_en = 1'b0; ug = 1'b0; mode = 2'b00;
    aar = '0; psc = '0; ccr = '0; pol = 4'b1010;
    #2;
    check_all("reset", 0, 1'b0, 1'b0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    check_all("disabled", 0, 1'b0, 1'b0, 4'b1010);
    ug = 1'b1;
    step();
    ug = 1'b0;
    check("ug ignored when disabled", 32'(upd_evt), 32'(0));

    // Up mode with preload change mid-period
    mode = 2'b00; aar = 16'd9; psc = 8'd0; pol = 4'b0000;
    ccr = {16'd0, 16'd12, 16'd0, 16'd3};
    step();
    check("up idle pwm", 32'(pwm_out), 32'(0));
    pwm_en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      int thr;
      step();
      thr = (k <= 40) ? 3 : 2;
      check_all($sformatf("up k=%0d", k), up_cnt(k), 1'b0,
                (k <= 40) ? (k % 10 == 0) : ((k - 40) % 6 == 0),
                {1'b0, 1'b1, 1'b0, (up_cnt(k - 1) < thr)});
      if (k == 34) begin
        aar = 16'd5;
        ccr = {16'd0, 16'd12, 16'd0, 16'd2};
      end
    end

    // Prescaler + up-down
    pwm_en = 1'b0;
    mode = 2'b01; aar = 16'd4; psc = 8'd2; ccr = {16'd0, 16'd12, 16'd0, 16'd2};
    step();
    check_all("ud idle", 0, 1'b0, 1'b0, 4'b0000);
    pwm_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      int t, p;
      step();
      t = k / 3;
      p = t % 8;
      check_all($sformatf("ud k=%0d", k), ud_cnt(k), (p >= 5) || (p == 0 && t > 0),
                (k % 3 == 0) && (p == 1) && (t > 1),
                {1'b0, 1'b1, 1'b0, (ud_cnt(k - 1) < 2)});
    end

    // Down mode with active-low channel 0
    pwm_en = 1'b0;
    mode = 2'b10; aar = 16'd7; psc = 8'd0; ccr = {16'd0, 16'd0, 16'd0, 16'd4}; pol = 4'b0001;
    step();
    check_all("down idle", 0, 1'b1, 1'b0, 4'b0001);
    pwm_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check_all($sformatf("down k=%0d", k), dn_cnt(k), 1'b1, (k % 8 == 1),
                {3'b000, 1'b1 ^ (dn_cnt(k - 1) < 4)});
    end

    // UG on the edge where the down counter would wrap 0->7
    ug = 1'b1;
    mode = 2'b00; aar = 16'd3; psc = 8'd2; ccr = {16'd0, 16'd0, 16'd0, 16'd1}; pol = 4'b0000;
    for (int j = 0; j <= 12; j++) begin
      step();
      ug = 1'b0;
      check_all($sformatf("ug j=%0d", j), ug_cnt(j), 1'b0,
                (j == 0) || ((j % 3 == 0) && (ug_cnt(j) == 0)),
                {3'b000, (j == 0) ? 1'b1 : (ug_cnt(j - 1) < 1)});
    end

    // Asynchronous reset mid-run, then recovery from zeroed shadows
    pol = 4'b1111;
    step();
    step();
    step();
    check("pre-reset cnt", 32'(cnt_val), 32'(1));
    check("pre-reset pwm", 32'(pwm_out), 32'(4'b1110));
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 0, 1'b0, 1'b0, 4'b0000);
    step();
    check_all("held reset", 0, 1'b0, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b1;
    step();
    check_all("recover 1", 0, 1'b0, 1'b1, 4'b1111);
    step();
    check_all("recover 2", 0, 1'b0, 1'b0, 4'b1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_timer_mc.md
Name: pwm_timer_mc

Overview:
- Multi-channel PWM timer: one shared prescaler and period counter drive NCH compare channels.
- Supports up, up-down (centre-aligned) and down counting.
- AAR, CCR and mode pass through shadow registers, so a new configuration takes effect only at an update event. A period change therefore never causes a glitch.
- Sits between the register interface and the output pads; next generation of the single-channel PWM counter.

Parameters:
- WIDTH, 16: width of counter, AAR and each CCR.
- NCH, 4: number of compare/PWM channels (1..16).
- PSC_W, 8: prescaler width.

Ports:
- clk  in  1  timer clock.
- rst_n  in  1  async reset, active low.
- PWM_EN  in  1  counter enable.
- mode  in  2  00 up, 01 up-down, 10 down, 11 treated as up.
- AAR  in  WIDTH  auto-reload (top) value, preload.
- PSC  in  PSC_W  prescaler; the counter ticks every PSC+1 clk.
- CCR  in  NCH*WIDTH  compare values; channel i = CCR[i*WIDTH +: WIDTH], preload.
- POL  in  NCH  output polarity per channel; 1 = active low. Not shadowed.
- UG  in  1  software update: one-clk pulse.
- cnt_val  out  WIDTH  current count.
- dir  out  1  0 = counting up, 1 = counting down.
- upd_evt  out  1  one-clk pulse on an update event.
- pwm_out  out  NCH  PWM outputs.

Behaviour:
- Reset (rst_n low, asynchronous): cnt_val=0, dir=0, upd_evt=0, pwm_out=0, prescaler=0, all shadows=0.
- Reset is also honoured mid-period; recovery occurs on the first clk after release.
- PWM_EN=0 (synchronous):
  - cnt_val=0, prescaler=0, dir=0 (dir=1 in down mode).
  - Shadows load from the inputs every clk.
  - upd_evt=0; pwm_out = POL (inactive level).
- Prescaler: psc_cnt counts 0..PSC_sh. tick=1 when psc_cnt==PSC_sh, and psc_cnt wraps to 0 on the same edge. PSC_sh is loaded at update events.
- Counter advances only on tick. The rules below use the shadow values.
- Up mode: if cnt >= AAR_sh then cnt <= 0 and update event; else cnt+1. dir=0.
- Down mode:
  - If cnt==0 then cnt <= AAR_sh and update event; else cnt-1. dir=1.
  - On enable, the first tick loads AAR_sh.
- Up-down mode:
  - dir=0: if cnt >= AAR_sh then dir<=1, cnt<=cnt-1; else cnt+1.
  - dir=1: if cnt==0 then dir<=0, cnt<=1, update event; else cnt-1.
  - Period is 2*AAR_sh ticks. Update occurs at the bottom only.
- Update event, on the same edge:
  - AAR_sh, CCR_sh[], mode_sh and PSC_sh load from the inputs.
  - upd_evt=1 for exactly one clk.
  - A mode change therefore applies from the next period, with dir reset to the new mode's start direction.
- UG=1 with PWM_EN=1:
  - cnt=0, prescaler=0, dir = start direction of mode (input mode).
  - Shadows load; upd_evt=1 next cycle.
  - UG has priority over a coincident tick and wrap.
  - UG with PWM_EN=0 is ignored.
- pwm_out, registered, one clk behind cnt_val:
  - pwm_out[i] <= POL[i] ^ (cnt_val < CCR_sh[i]) when PWM_EN=1.
  - CCR_sh[i]=0 gives 0% duty.
  - CCR_sh[i] > AAR_sh gives 100% duty.
  - In up-down mode the pulse is centred on count 0.
- Edge cases:
  - AAR_sh=0: cnt stays 0 and an update event occurs every tick.
  - AAR decreased below the current cnt: no effect until the update event.
- All arithmetic is unsigned WIDTH-bit; no overflow is reachable because cnt never exceeds AAR_sh.

Test Plan:
- Reset sequence: rst_n=0 with mid-run activity -> all outputs 0 immediately. After release with PWM_EN=0 -> pwm_out=POL.
- Up mode: AAR=9, PSC=0, CCR0=3, CCR1=0, CCR2=12, POL=0 ->
  - cnt 0..9 repeating; upd_evt every 10 clk at the 9->0 wrap.
  - pwm_out[0] high 3 of 10 clk, lagging cnt by 1.
  - ch1 always low; ch2 always high.
- Prescaler plus up-down: AAR=4, PSC=2, mode=01 ->
  - cnt 0,1,2,3,4,3,2,1,0,1..., each value held 3 clk.
  - dir=1 from the 4 to the 0; upd_evt only at the 0->1 turn; period 24 clk.
- Preload: write AAR=5 and CCR0=2 mid-period of AAR=9 ->
  - old period completes to 9; the new values take effect after the upd_evt.
  - No period shorter than either setting appears.
- Down mode and POL: mode=10, AAR=7, CCR0=4, POL0=1 ->
  - sequence 7..0; upd_evt at 0->7.
  - pwm_out[0] low while cnt<4.
- UG while a tick coincides with a wrap -> cnt=0, prescaler=0, a single upd_evt, shadows hold the current inputs.
